aobureg_seq: RTL and testbench

- APB master sequencer sitting directly upstream of the always-on backup-register file.
- On a save request it streams up to REGCNT 32-bit words from a producer into consecutive backup registers.
- On a restore request it reads them back out to a consumer stream.
- Used by the power-management flow around deep-sleep entry and exit, so firmware does not hand-sequence register writes.

---
 rtl/aobureg_pkg.sv | 28 ++
 rtl/aobureg_apbm.sv | 100 ++++++++++
 rtl/aobureg_seq.sv | 170 +++++++++++++++++
 tb/tb_aobureg_seq.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aobureg_pkg.sv
// Shared types and constants for the backup-register APB sequencer.
//   seq_state_e   : top-level sequencer states
//   apb_phase_e   : phases of the single-transfer APB master
//   ADDR_STRIDE   : byte distance between consecutive backup registers
//   TOCNT_DEFAULT : default ACCESS-phase wait limit
package aobureg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SV_WAIT,
    ST_SV_SETUP,
    ST_SV_ACCESS,
    ST_RS_SETUP,
    ST_RS_ACCESS,
    ST_RS_OUT,
    ST_FIN
  } seq_state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_ACCESS
  } apb_phase_e;

  localparam int unsigned ADDR_STRIDE   = 4;
  localparam int unsigned TOCNT_DEFAULT = 255;

endpackage

// File: rtl/aobureg_apbm.sv
// Single-transfer APB master. A start pulse (only honoured when idle) latches
// wr/addr/wdata and runs one SETUP + ACCESS sequence. ACCESS ends on pready
// or after TOCNT cycles without it.
//   pclk, resetn        : clock, synchronous active-low reset
//   start_i/wr_i/addr_i/wdata_i : transfer request
//   done_o              : pulse in the ACCESS cycle that sees pready
//   err_o               : done_o qualified by pslverr
//   timeout_o           : pulse in the last ACCESS cycle without pready
//   rdata_o             : read data, valid with done_o
//   psel_o..pslverr_i   : APB master interface
module aobureg_apbm
  import aobureg_pkg::*;
#(
  parameter int unsigned AW    = 12,
  parameter int unsigned TOCNT = TOCNT_DEFAULT
) (
  input  logic          pclk,
  input  logic          resetn,
  input  logic          start_i,
  input  logic          wr_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic          done_o,
  output logic [31:0]   rdata_o,
  output logic          err_o,
  output logic          timeout_o,
  output logic          psel_o,
  output logic          penable_o,
  output logic          pwrite_o,
  output logic [AW-1:0] paddr_o,
  output logic [31:0]   pwdata_o,
  input  logic [31:0]   prdata_i,
  input  logic          pready_i,
  input  logic          pslverr_i
);

  // Down-counter loaded on entry to ACCESS; terminal count 0 marks the
  // TOCNT-th ACCESS cycle.
  localparam logic [15:0] WAIT_LOAD = 16'(TOCNT - 1);

  apb_phase_e    phase_q, phase_d;
  logic [15:0]   wait_q, wait_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;

  always_ff @(posedge pclk) begin
    if (!resetn) begin
      phase_q <= PH_IDLE;
      wait_q  <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      phase_q <= phase_d;
      wait_q  <= wait_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    wait_d  = wait_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (phase_q)
      PH_IDLE: begin
        if (start_i) begin
          phase_d = PH_SETUP;
          wr_d    = wr_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
        end
      end
      PH_SETUP: begin
        phase_d = PH_ACCESS;
        wait_d  = WAIT_LOAD;
      end
      PH_ACCESS: begin
        if (pready_i || (wait_q == '0)) phase_d = PH_IDLE;
        else                            wait_d  = wait_q - 16'd1;
      end
      default: phase_d = PH_IDLE;
    endcase
  end

  assign psel_o    = (phase_q != PH_IDLE);
  assign penable_o = (phase_q == PH_ACCESS);
  assign pwrite_o  = wr_q;
  assign paddr_o   = addr_q;
  assign pwdata_o  = wdata_q;
  assign done_o    = penable_o & pready_i;
  assign err_o     = done_o & pslverr_i;
  assign timeout_o = penable_o & ~pready_i & (wait_q == '0);
  assign rdata_o   = prdata_i;

endmodule

// File: rtl/aobureg_seq.sv
// Save/restore sequencer for the always-on backup-register file. A save
// streams up to REGCNT words from sv_* into consecutive registers over APB;
// a restore reads them back out on rs_*.
//   pclk, resetn           : clock, synchronous active-low reset
//   save_req/restore_req   : start pulses (save wins), len words (clamped)
//   busy/done/err          : status; err is sticky until the next request
//   sv_valid/sv_data/sv_ready : save input stream
//   rs_valid/rs_data/rs_ready : restore output stream
//   m_*                    : APB master toward the backup-register file
//
// state     | meaning
// IDLE      | waiting for a request
// SV_WAIT   | waiting for the next save word
// SV_SETUP  | APB write SETUP phase
// SV_ACCESS | APB write ACCESS phase
// RS_SETUP  | APB read SETUP phase
// RS_ACCESS | APB read ACCESS phase
// RS_OUT    | presenting a restored word until rs_ready
// FIN       | one-cycle done pulse
module aobureg_seq
  import aobureg_pkg::*;
#(
  parameter int unsigned REGCNT = 8,
  parameter int unsigned BASE   = 0,
  parameter int unsigned AW     = 12,
  parameter int unsigned TOCNT  = TOCNT_DEFAULT
) (
  input  logic                         pclk,
  input  logic                         resetn,
  input  logic                         save_req,
  input  logic                         restore_req,
  input  logic [$clog2(REGCNT+1)-1:0]  len,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  input  logic                         sv_valid,
  input  logic [31:0]                  sv_data,
  output logic                         sv_ready,
  output logic                         rs_valid,
  output logic [31:0]                  rs_data,
  input  logic                         rs_ready,
  output logic                         m_psel,
  output logic                         m_penable,
  output logic                         m_pwrite,
  output logic [AW-1:0]                m_paddr,
  output logic [31:0]                  m_pwdata,
  input  logic [31:0]                  m_prdata,
  input  logic                         m_pready,
  input  logic                         m_pslverr
);

  localparam int unsigned LW = $clog2(REGCNT + 1);
  localparam int unsigned IW = (REGCNT > 1) ? $clog2(REGCNT) : 1;

  seq_state_e    state_q, state_d;
  logic [LW-1:0] rem_q, rem_d, len_c;
  logic [IW-1:0] idx_q, idx_d;
  logic          err_q, err_d;
  logic [31:0]   rs_data_q, rs_data_d;

  logic          ap_start, ap_wr, ap_done, ap_err, ap_timeout;
  logic [AW-1:0] ap_addr;
  logic [31:0]   ap_rdata;

  always_ff @(posedge pclk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      rs_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      rs_data_q <= rs_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    err_d     = err_q;
    rs_data_d = rs_data_q;
    len_c     = (len > LW'(REGCNT)) ? LW'(REGCNT) : len;
    case (state_q)
      ST_IDLE: begin
        if (save_req || restore_req) begin
          rem_d = len_c;
          idx_d = '0;
          err_d = 1'b0;
          if (len_c == '0)   state_d = ST_FIN;
          else if (save_req) state_d = ST_SV_WAIT;
          else               state_d = ST_RS_SETUP;
        end
      end
      ST_SV_WAIT:  if (sv_valid) state_d = ST_SV_SETUP;
      ST_SV_SETUP: state_d = ST_SV_ACCESS;
      ST_SV_ACCESS: begin
        if (ap_timeout || ap_err) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else if (ap_done) begin
          idx_d   = idx_q + IW'(1);
          rem_d   = rem_q - LW'(1);
          state_d = (rem_q == LW'(1)) ? ST_FIN : ST_SV_WAIT;
        end
      end
      ST_RS_SETUP: state_d = ST_RS_ACCESS;
      ST_RS_ACCESS: begin
        if (ap_timeout || ap_err) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else if (ap_done) begin
          rs_data_d = ap_rdata;
          state_d   = ST_RS_OUT;
        end
      end
      ST_RS_OUT: begin
        if (rs_ready) begin
          idx_d   = idx_q + IW'(1);
          rem_d   = rem_q - LW'(1);
          state_d = (rem_q == LW'(1)) ? ST_FIN : ST_RS_SETUP;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The master is kicked on the edge that enters a SETUP state so that its
  // SETUP phase coincides with ours; the address uses the updated index.
  assign ap_start = (state_d == ST_SV_SETUP) || (state_d == ST_RS_SETUP);
  assign ap_wr    = (state_d == ST_SV_SETUP);
  assign ap_addr  = AW'(BASE) + AW'(idx_d) * AW'(ADDR_STRIDE);

  aobureg_apbm #(
    .AW    (AW),
    .TOCNT (TOCNT)
  ) u_apbm (
    .pclk      (pclk),
    .resetn    (resetn),
    .start_i   (ap_start),
    .wr_i      (ap_wr),
    .addr_i    (ap_addr),
    .wdata_i   (sv_data),
    .done_o    (ap_done),
    .rdata_o   (ap_rdata),
    .err_o     (ap_err),
    .timeout_o (ap_timeout),
    .psel_o    (m_psel),
    .penable_o (m_penable),
    .pwrite_o  (m_pwrite),
    .paddr_o   (m_paddr),
    .pwdata_o  (m_pwdata),
    .prdata_i  (m_prdata),
    .pready_i  (m_pready),
    .pslverr_i (m_pslverr)
  );

  assign busy     = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign done     = (state_q == ST_FIN);
  assign err      = err_q;
  assign sv_ready = (state_q == ST_SV_WAIT);
  assign rs_valid = (state_q == ST_RS_OUT);
  assign rs_data  = rs_data_q;

endmodule

// File: tb/tb_aobureg_seq.sv
module tb_aobureg_seq;
  localparam int AW = 12;
  localparam int LW = 4;

  logic          pclk = 1'b0;
  logic          resetn, save_req, restore_req;
  logic [LW-1:0] len;
  logic          busy, done, err;
  logic          sv_valid, sv_ready, rs_valid, rs_ready;
  logic [31:0]   sv_data, rs_data;
  logic          m_psel, m_penable, m_pwrite, m_pready, m_pslverr;
  logic [AW-1:0] m_paddr;
  logic [31:0]   m_pwdata, m_prdata;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] rd_mem   [0:7];
  logic [31:0] sv_words [0:7];
  int          sv_n = 0;

  int slv_wait   = 0;
  bit slv_never  = 0;
  int slv_err_at = -1;

  int acc_cnt = 0, xfer_n = 0, wr_n = 0, rd_n = 0, run_cur = 0, acc_run = 0;
  bit stab_bad = 0, proto_bad = 0, prev_setup = 0;
  logic [AW-1:0] wr_addr [0:63];
  logic [AW-1:0] rd_addr [0:63];
  logic [31:0]   wr_data [0:63];
  logic [AW-1:0] cap_addr = '0;
  logic [31:0]   cap_wdata = '0;
  logic          cap_wr = 1'b0;

  aobureg_seq #(.REGCNT(8), .BASE(0), .AW(AW), .TOCNT(10)) dut (
    .pclk(pclk), .resetn(resetn), .save_req(save_req), .restore_req(restore_req),
    .len(len), .busy(busy), .done(done), .err(err),
    .sv_valid(sv_valid), .sv_data(sv_data), .sv_ready(sv_ready),
    .rs_valid(rs_valid), .rs_data(rs_data), .rs_ready(rs_ready),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_prdata(m_prdata),
    .m_pready(m_pready), .m_pslverr(m_pslverr)
  );

  always #5 pclk = ~pclk;

  // APB slave model: programmable wait states, error injection, logging
  assign m_pready  = m_psel && m_penable && !slv_never && (acc_cnt >= slv_wait);
  assign m_pslverr = m_pready && (xfer_n == slv_err_at);
  assign m_prdata  = rd_mem[m_paddr[4:2]];

  always @(posedge pclk) begin
    if (m_psel && m_penable && !m_pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (m_psel && m_penable) run_cur <= run_cur + 1;
    else if (run_cur != 0) begin
      acc_run <= run_cur;
      run_cur <= 0;
    end
    if (m_psel && m_penable && m_pready) begin
      xfer_n <= xfer_n + 1;
      if (m_pwrite) begin
        if (wr_n < 64) begin
          wr_addr[wr_n] <= m_paddr;
          wr_data[wr_n] <= m_pwdata;
        end
        wr_n <= wr_n + 1;
      end else begin
        if (rd_n < 64) rd_addr[rd_n] <= m_paddr;
        rd_n <= rd_n + 1;
      end
    end
    if (m_psel && !m_penable) begin
      cap_addr  <= m_paddr;
      cap_wdata <= m_pwdata;
      cap_wr    <= m_pwrite;
    end
    if (m_psel && m_penable &&
        (m_paddr != cap_addr || m_pwrite != cap_wr || (m_pwrite && m_pwdata != cap_wdata)))
      stab_bad <= 1'b1;
    if (prev_setup && resetn && !(m_psel && m_penable)) proto_bad <= 1'b1;
    prev_setup <= m_psel && !m_penable;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge pclk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input bit sv, input bit rs, input int n);
    save_req    = sv;
    restore_req = rs;
    len         = n[LW-1:0];
    tick();
    save_req    = 1'b0;
    restore_req = 1'b0;
  endtask

  // Runs from the negedge after acceptance until done, feeding sv_words.
  task automatic run_op(input int maxc, output int cyc);
    int  k;
    logic pend;
    k = 0;
    cyc = 0;
    sv_valid = (sv_n > 0);
    sv_data  = sv_words[0];
    while (!done && cyc < maxc) begin
      pend = sv_ready && sv_valid;
      tick();
      cyc++;
      if (pend) begin
        k++;
        if (k < sv_n) sv_data = sv_words[k];
        else sv_valid = 1'b0;
      end
    end
    chk("op_done_seen", {31'd0, done}, 32'd1);
    sv_valid = 1'b0;
  endtask

  initial begin
    int c, wb, rb, xb, i, pulses;
    resetn = 1'b0; save_req = 1'b0; restore_req = 1'b0; len = '0;
    sv_valid = 1'b0; sv_data = '0; rs_ready = 1'b0;
    rd_mem[0] = 32'h1234;
    rd_mem[1] = 32'h5678;
    for (int j = 2; j < 8; j++) rd_mem[j] = 32'hC0DE0000 + j;
    repeat (3) tick();
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_psel", {31'd0, m_psel}, 0);
    chk("rst_sv_ready", {31'd0, sv_ready}, 0);
    chk("rst_rs_valid", {31'd0, rs_valid}, 0);
    resetn = 1'b1;
    tick();

    // save of three words, zero-wait slave
    sv_words[0] = 32'hA1; sv_words[1] = 32'hB2; sv_words[2] = 32'hC3; sv_n = 3;
    wb = wr_n;
    accept(1, 0, 3);
    chk("save_busy", {31'd0, busy}, 1);
    run_op(40, c);
    chk("save_cycles", c, 9);
    chk("save_err", {31'd0, err}, 0);
    chk("save_nwr", wr_n - wb, 3);
    chk("save_a0", {20'd0, wr_addr[wb]}, 32'h0);
    chk("save_a1", {20'd0, wr_addr[wb+1]}, 32'h4);
    chk("save_a2", {20'd0, wr_addr[wb+2]}, 32'h8);
    chk("save_d0", wr_data[wb], 32'hA1);
    chk("save_d1", wr_data[wb+1], 32'hB2);
    chk("save_d2", wr_data[wb+2], 32'hC3);
    tick();
    chk("save_done_once", {31'd0, done}, 0);
    chk("save_busy_end", {31'd0, busy}, 0);

    // restore of two words with a 4-cycle stall on word 0
    sv_n = 0; rs_ready = 1'b0; rb = rd_n;
    accept(0, 1, 2);
    i = 0;
    while (!rs_valid && i < 20) begin tick(); i++; end
    chk("rs0_latency", i, 2);
    for (int s = 0; s < 4; s++) begin
      chk("rs_stall_data", rs_data, 32'h1234);
      chk("rs_stall_psel", {31'd0, m_psel}, 0);
      tick();
    end
    chk("rs_stall_nrd", rd_n - rb, 1);
    rs_ready = 1'b1;
    tick();
    rs_ready = 1'b0;
    i = 0;
    while (!rs_valid && i < 20) begin tick(); i++; end
    chk("rs1_data", rs_data, 32'h5678);
    rs_ready = 1'b1;
    i = 0;
    while (!done && i < 20) begin tick(); i++; end
    chk("rs_done", {31'd0, done}, 1);
    chk("rs_a0", {20'd0, rd_addr[rb]}, 32'h0);
    chk("rs_a1", {20'd0, rd_addr[rb+1]}, 32'h4);
    tick();
    rs_ready = 1'b0;

    // five wait states on every access
    slv_wait = 5;
    sv_words[0] = 32'hDEAD0001; sv_words[1] = 32'hBEEF0002; sv_n = 2;
    wb = wr_n;
    accept(1, 0, 2);
    run_op(60, c);
    chk("wait_save_cycles", c, 16);
    chk("wait_save_d1", wr_data[wb+1], 32'hBEEF0002);
    chk("wait_save_a1", {20'd0, wr_addr[wb+1]}, 32'h4);
    tick();
    sv_n = 0; rs_ready = 1'b1;
    accept(0, 1, 1);
    run_op(40, c);
    chk("wait_rs_cycles", c, 8);
    chk("wait_rs_data", rs_data, 32'h1234);
    chk("apb_stable", {31'd0, stab_bad}, 0);
    tick();
    rs_ready = 1'b0;
    slv_wait = 0;

    // slave error on word 1 of a four-word save
    for (int j = 0; j < 4; j++) sv_words[j] = 32'h100 + j;
    sv_n = 4; wb = wr_n;
    slv_err_at = xfer_n + 1;
    accept(1, 0, 4);
    run_op(40, c);
    chk("slverr_cycles", c, 6);
    chk("slverr_err", {31'd0, err}, 1);
    chk("slverr_nwr", wr_n - wb, 2);
    tick();
    slv_err_at = -1;
    chk("slverr_busy", {31'd0, busy}, 0);
    chk("slverr_sticky", {31'd0, err}, 1);
    sv_words[0] = 32'h77; sv_n = 1;
    accept(1, 0, 1);
    chk("err_cleared", {31'd0, err}, 0);
    run_op(20, c);
    tick();

    // timeout with a slave that never answers
    slv_never = 1'b1;
    sv_words[0] = 32'h99; sv_n = 1; wb = wr_n;
    accept(1, 0, 1);
    run_op(40, c);
    chk("to_cycles", c, 12);
    chk("to_err", {31'd0, err}, 1);
    tick();
    chk("to_access_len", acc_run, 10);
    chk("to_psel", {31'd0, m_psel}, 0);
    chk("to_nwr", wr_n - wb, 0);
    slv_never = 1'b0;

    // simultaneous requests: save wins
    sv_words[0] = 32'h55; sv_n = 1; wb = wr_n; rb = rd_n;
    accept(1, 1, 1);
    chk("both_sv_ready", {31'd0, sv_ready}, 1);
    run_op(20, c);
    chk("both_nwr", wr_n - wb, 1);
    chk("both_nrd", rd_n - rb, 0);
    tick();

    // len zero
    xb = xfer_n;
    accept(1, 0, 0);
    chk("len0_done", {31'd0, done}, 1);
    chk("len0_busy", {31'd0, busy}, 0);
    chk("len0_psel", {31'd0, m_psel}, 0);
    tick();
    chk("len0_noxfer", xfer_n - xb, 0);

    // len above REGCNT clamps to REGCNT
    sv_n = 0; rs_ready = 1'b1; rb = rd_n;
    accept(0, 1, 15);
    run_op(60, c);
    chk("clamp_cycles", c, 24);
    chk("clamp_nrd", rd_n - rb, 8);
    chk("clamp_last_addr", {20'd0, rd_addr[rb+7]}, 32'h1C);
    chk("clamp_last_data", rs_data, 32'hC0DE0007);
    tick();
    rs_ready = 1'b0;

    // reset in the middle of ACCESS
    slv_never = 1'b1;
    sv_n = 0;
    accept(1, 0, 1);
    sv_valid = 1'b1; sv_data = 32'h5A5A5A5A;
    i = 0;
    while (!m_penable && i < 10) begin tick(); i++; end
    sv_valid = 1'b0;
    chk("mid_access", {31'd0, m_penable}, 1);
    chk("mid_pwdata", m_pwdata, 32'h5A5A5A5A);
    resetn = 1'b0;
    tick();
    chk("rmid_psel", {31'd0, m_psel}, 0);
    chk("rmid_penable", {31'd0, m_penable}, 0);
    chk("rmid_pwrite", {31'd0, m_pwrite}, 0);
    chk("rmid_pwdata", m_pwdata, 0);
    chk("rmid_busy", {31'd0, busy}, 0);
    chk("rmid_sv_ready", {31'd0, sv_ready}, 0);
    chk("rmid_rs_data", rs_data, 0);
    resetn = 1'b1;
    slv_never = 1'b0;
    pulses = 0;
    for (int s = 0; s < 4; s++) begin
      tick();
      if (done) pulses++;
    end
    chk("rmid_no_done", pulses, 0);
    chk("apb_setup_then_access", {31'd0, proto_bad}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
